// File: rtl/quad_step_decoder.sv
// Quadrature encoder front end: two-flop synchronisers, per-channel debounce,
// and Gray-code decode into a step pulse, direction level and error reporting.
module quad_step_decoder #(
    parameter int FILT_LEN   = 4,
    parameter int SETTLE_LEN = FILT_LEN + 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       a_in,
    input  logic       b_in,
    input  logic       err_clr,
    output logic       step,
    output logic       direc,
    output logic       err,
    output logic       err_flag,
    output logic [1:0] ab_filt
);
    localparam int FCW = 4;
    localparam int SCW = $clog2(SETTLE_LEN + 1);
    localparam logic [FCW-1:0] FC_LAST = FCW'(FILT_LEN - 1);
    localparam logic [SCW-1:0] SC_LAST = SCW'(SETTLE_LEN - 1);

    typedef enum logic [0:0] {
        SETTLE = 1'b0,
        RUN    = 1'b1
    } state_t;

    state_t              state_r, state_s;
    logic [SCW-1:0]      settle_cnt_r, settle_cnt_s;
    logic [1:0]          sync1_r, sync2_r;
    logic [1:0]          filt_r, filt_s;
    logic [1:0]          prev_r;
    logic [1:0][FCW-1:0] fc_r, fc_s;
    logic                step_s, direc_s, err_s, err_flag_s;

    // True when {A,B} moving from from_ab to to_ab is one step of the up sequence.
    function automatic logic is_up(input logic [1:0] from_ab, input logic [1:0] to_ab);
        case ({from_ab, to_ab})
            4'b0010, 4'b1011, 4'b1101, 4'b0100: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    // Settle sequencing and per-channel debounce next-state.
    always_comb begin
        state_s      = state_r;
        settle_cnt_s = settle_cnt_r;
        filt_s       = filt_r;
        fc_s         = fc_r;
        case (state_r)
            SETTLE: begin
                // Filter bypassed so ab_filt reflects the pins once decoding starts.
                filt_s = sync2_r;
                fc_s   = '0;
                if (settle_cnt_r == SC_LAST) begin
                    state_s      = RUN;
                    settle_cnt_s = '0;
                end else begin
                    settle_cnt_s = settle_cnt_r + SCW'(1);
                end
            end
            RUN: begin
                for (int i = 0; i < 2; i++) begin
                    if (sync2_r[i] == filt_r[i]) begin
                        fc_s[i] = '0;
                    end else if (fc_r[i] == FC_LAST) begin
                        filt_s[i] = sync2_r[i];
                        fc_s[i]   = '0;
                    end else begin
                        fc_s[i] = fc_r[i] + FCW'(1);
                    end
                end
            end
            default: begin
                state_s      = SETTLE;
                settle_cnt_s = '0;
            end
        endcase
    end

    // Decode of the previous/current filtered pair and sticky error update.
    always_comb begin
        step_s     = 1'b0;
        err_s      = 1'b0;
        direc_s    = direc;
        err_flag_s = err_flag;
        if (state_r == RUN) begin
            case (prev_r ^ filt_r)
                2'b11: begin
                    err_s = 1'b1;
                end
                2'b01, 2'b10: begin
                    if (en) begin
                        step_s  = 1'b1;
                        direc_s = is_up(prev_r, filt_r);
                    end else begin
                        step_s = 1'b0;
                    end
                end
                default: begin
                    step_s = 1'b0;
                end
            endcase
        end else begin
            step_s = 1'b0;
        end
        if (err_s) begin
            err_flag_s = 1'b1;
        end else if (err_clr) begin
            err_flag_s = 1'b0;
        end else begin
            err_flag_s = err_flag;
        end
    end

    // State, filter and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= SETTLE;
            settle_cnt_r <= '0;
            sync1_r      <= 2'b00;
            sync2_r      <= 2'b00;
            filt_r       <= 2'b00;
            prev_r       <= 2'b00;
            fc_r         <= '0;
            step         <= 1'b0;
            direc        <= 1'b0;
            err          <= 1'b0;
            err_flag     <= 1'b0;
        end else begin
            state_r      <= state_s;
            settle_cnt_r <= settle_cnt_s;
            sync1_r      <= {a_in, b_in};
            sync2_r      <= sync1_r;
            filt_r       <= filt_s;
            prev_r       <= filt_r;
            fc_r         <= fc_s;
            step         <= step_s;
            direc        <= direc_s;
            err          <= err_s;
            err_flag     <= err_flag_s;
        end
    end

    assign ab_filt = filt_r;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: directed scenarios then random pin activity,
// every cycle compared against a sample-window reference model.
module tb_quad_step_decoder;
    localparam int FILT_LEN   = 4;
    localparam int SETTLE_LEN = FILT_LEN + 2;

    logic       clk = 1'b0;
    logic       rst, en, a_in, b_in, err_clr;
    logic       step, direc, err, err_flag;
    logic [1:0] ab_filt;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: pin history (bit 0 newest capture) and outputs.
    logic [15:0] ha, hb;
    logic [1:0]  m_filt, m_prev;
    logic        m_step, m_direc, m_err, m_flag;
    int          edges_done;

    // Tallies for directed scenarios.
    int         n_step, n_up, n_err, cyc_idx, first_step;
    logic [3:0] cnt4;

    always #5 clk = ~clk;

    quad_step_decoder #(.FILT_LEN(FILT_LEN), .SETTLE_LEN(SETTLE_LEN)) dut (
        .clk(clk), .rst(rst), .en(en), .a_in(a_in), .b_in(b_in), .err_clr(err_clr),
        .step(step), .direc(direc), .err(err), .err_flag(err_flag), .ab_filt(ab_filt)
    );

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Position of an {A,B} code along the up sequence 00,10,11,01.
    function automatic int pos(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    // A filtered bit flips when the last FILT_LEN synchronised samples all disagree with it.
    function automatic logic window_differs(input logic [15:0] h, input logic f);
        logic all_d;
        all_d = 1'b1;
        for (int j = 1; j <= FILT_LEN; j++) begin
            if (h[j] == f) all_d = 1'b0;
        end
        return all_d;
    endfunction

    task automatic model_reset();
        ha = '0; hb = '0;
        m_filt = 2'b00; m_prev = 2'b00;
        m_step = 1'b0; m_direc = 1'b0; m_err = 1'b0; m_flag = 1'b0;
        edges_done = 0;
    endtask

    task automatic model_step(input logic a, input logic b, input logic en_v, input logic clr_v);
        logic [1:0] nf;
        int d;
        logic run;
        run = (edges_done >= SETTLE_LEN);
        if (!run) begin
            nf = {ha[1], hb[1]};
        end else begin
            nf = m_filt;
            if (window_differs(ha, m_filt[1])) nf[1] = ~m_filt[1];
            if (window_differs(hb, m_filt[0])) nf[0] = ~m_filt[0];
        end
        m_step = 1'b0;
        m_err  = 1'b0;
        if (run) begin
            d = (pos(m_filt) - pos(m_prev) + 4) % 4;
            if (d == 2) m_err = 1'b1;
            else if (d != 0 && en_v) begin
                m_step  = 1'b1;
                m_direc = (d == 1);
            end
        end
        if (m_err) m_flag = 1'b1;
        else if (clr_v) m_flag = 1'b0;
        m_prev = m_filt;
        m_filt = nf;
        ha = {ha[14:0], a};
        hb = {hb[14:0], b};
        edges_done++;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step(a_in, b_in, en, err_clr);
        @(negedge clk);
        cyc_idx++;
        chk2("step", {1'b0, step}, {1'b0, m_step});
        chk2("direc", {1'b0, direc}, {1'b0, m_direc});
        chk2("err", {1'b0, err}, {1'b0, m_err});
        chk2("err_flag", {1'b0, err_flag}, {1'b0, m_flag});
        chk2("ab_filt", ab_filt, m_filt);
        if (step) begin
            n_step++;
            if (direc) n_up++;
            if (first_step < 0) first_step = cyc_idx;
            cnt4 = direc ? cnt4 + 4'd1 : cnt4 - 4'd1;
        end
        if (err) n_err++;
    endtask

    task automatic hold(input logic [1:0] ab, input int n);
        {a_in, b_in} = ab;
        repeat (n) cyc();
    endtask

    task automatic clear_tallies();
        n_step = 0; n_up = 0; n_err = 0; cyc_idx = 0; first_step = -1; cnt4 = 4'd0;
    endtask

    task automatic chk_zero(input string tag);
        chk2({tag, "_step"}, {1'b0, step}, 2'b00);
        chk2({tag, "_direc"}, {1'b0, direc}, 2'b00);
        chk2({tag, "_err"}, {1'b0, err}, 2'b00);
        chk2({tag, "_flag"}, {1'b0, err_flag}, 2'b00);
        chk2({tag, "_ab"}, ab_filt, 2'b00);
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; err_clr = 1'b0; a_in = 1'b1; b_in = 1'b1;
        model_reset();
        clear_tallies();
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b1;

        // Pins held at 11 through settle.
        hold(2'b11, SETTLE_LEN);
        chk2("settle_ab", ab_filt, 2'b11);
        hold(2'b11, 4);
        chk_int("settle_steps", n_step, 0);
        chk_int("settle_errs", n_err, 0);
        hold(2'b01, 10);
        hold(2'b00, 10);

        // Full up cycle.
        clear_tallies();
        hold(2'b10, 10); hold(2'b11, 10); hold(2'b01, 10); hold(2'b00, 10);
        chk_int("up_steps", n_step, 4);
        chk_int("up_dir", n_up, 4);
        chk_int("up_latency", first_step, FILT_LEN + 3);

        // Full down cycle into a 4-bit counter from 0.
        clear_tallies();
        hold(2'b01, 10); hold(2'b11, 10); hold(2'b10, 10); hold(2'b00, 10);
        chk_int("down_steps", n_step, 4);
        chk_int("down_dir", n_up, 0);
        chk_int("down_count", int'(cnt4), 12);

        // Glitch shorter than the filter, then one exactly as long.
        clear_tallies();
        hold(2'b10, FILT_LEN - 1); hold(2'b00, 12);
        chk_int("glitch_steps", n_step, 0);
        chk_int("glitch_errs", n_err, 0);
        chk2("glitch_ab", ab_filt, 2'b00);
        hold(2'b10, FILT_LEN); hold(2'b00, 12);
        chk_int("pulse_steps", n_step, 2);

        // Double-bit change, clear, then clear racing a new error.
        clear_tallies();
        hold(2'b11, 12);
        chk_int("dbl_errs", n_err, 1);
        chk_int("dbl_steps", n_step, 0);
        chk2("dbl_flag", {1'b0, err_flag}, 2'b01);
        err_clr = 1'b1; cyc(); err_clr = 1'b0; cyc();
        chk2("clr_flag", {1'b0, err_flag}, 2'b00);
        clear_tallies();
        err_clr = 1'b1;
        {a_in, b_in} = 2'b00;
        repeat (12) begin
            cyc();
            if (err) chk2("flag_prio", {1'b0, err_flag}, 2'b01);
        end
        err_clr = 1'b0;
        chk_int("prio_errs", n_err, 1);

        // Transitions while disabled leave no stale step.
        clear_tallies();
        en = 1'b0;
        hold(2'b10, 10); hold(2'b11, 10);
        en = 1'b1;
        hold(2'b11, 10);
        chk_int("en_steps", n_step, 0);

        // Mid-operation asynchronous reset, then settle repeats.
        hold(2'b00, 12);
        hold(2'b10, 8);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 chk_zero("async_rst");
        model_reset();
        repeat (3) @(negedge clk);
        chk_zero("held_rst");
        rst = 1'b1;
        clear_tallies();
        hold(2'b10, SETTLE_LEN + 4);
        chk2("resettle_ab", ab_filt, 2'b10);
        chk_int("resettle_steps", n_step, 0);

        // Random pin activity, including glitches, illegal jumps, en and err_clr.
        repeat (250) begin
            en      = ($urandom_range(0, 7) != 0);
            err_clr = ($urandom_range(0, 9) == 0);
            hold(2'($urandom_range(0, 3)), $urandom_range(1, 12));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/quad_step_decoder.md
Name: quad_step_decoder

Overview:
- Upstream front end for the 4-bit up/down counter.
- Takes two raw quadrature inputs (A/B from a rotary encoder), synchronises and debounces them, then decodes the Gray-code sequence.
- Outputs a one-cycle step pulse plus a direction level, which drive the counter's count-enable and direc inputs.
- Flags illegal double-bit transitions as errors.

Parameters:
- FILT_LEN, 4, consecutive clk cycles a synchronised input must differ from its filtered value before the filtered value updates. Legal range 1..15.
- SETTLE_LEN, FILT_LEN+2, cycles after reset release during which decoding is suppressed.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  decode enable. When 0, step is suppressed but filtering and tracking continue.
- a_in  input  1  raw encoder channel A, asynchronous.
- b_in  input  1  raw encoder channel B, asynchronous.
- err_clr  input  1  synchronous clear of err_flag.
- step  output  1  one-cycle pulse per legal quadrature transition.
- direc  output  1  1 = up, 0 = down. Valid when step=1; holds its last value otherwise.
- err  output  1  one-cycle pulse on an illegal transition.
- err_flag  output  1  sticky error; set by err, cleared by err_clr.
- ab_filt  output  2  debounced {A,B}, for observation.

Behaviour:
- Reset (rst=0, asynchronous) drives everything to 0: sync FFs, filt, prev, filter counters, settle counter; step=0, direc=0, err=0, err_flag=0, ab_filt=2'b00. FSM enters SETTLE.
- Synchroniser: two-flop chain per channel. sync2 reflects the pin 2 edges after capture.
- Debounce, per channel, independently, with a counter fc:
  - sync2==filt: fc<=0.
  - sync2!=filt and fc<FILT_LEN-1: fc<=fc+1.
  - sync2!=filt and fc==FILT_LEN-1: filt<=sync2, fc<=0.
  - A glitch shorter than FILT_LEN cycles never reaches filt.
- prev register: prev<=filt every cycle. A transition is detected when filt!=prev.
- FSM:
  - SETTLE: filt tracks sync2 directly (no debounce). step and err are forced 0. Settle counter runs SETTLE_LEN cycles, then moves to RUN.
  - RUN: normal decode. No other states; only reset returns to SETTLE.
- Decode (RUN), evaluated on {prev,filt}, outputs registered one cycle later:
  - Up sequence (A leads B): 00->10->11->01->00. Any such pair gives step=1, direc=1.
  - Down sequence: 00->01->11->10->00. Gives step=1, direc=0.
  - Both bits changed (00<->11, 01<->10): err=1, err_flag<=1, step=0, direc unchanged.
  - No change: step=0, err=0.
- en=0: step forced 0 and direc held; prev still updates, so no stale step appears on re-enable. err is still reported regardless of en.
- err_flag:
  - Set has priority over err_clr in the same cycle.
  - err_clr with no concurrent err clears on the next edge.
- Latency: a clean pin edge captured at edge k produces step high in the cycle after edge k+FILT_LEN+2. For FILT_LEN=4, that is 6 edges after capture.
- Maximum legal input rate: one transition per FILT_LEN+1 cycles. Faster edges are absorbed by the filter.
- Reset asserted mid-operation: all outputs go 0 immediately (asynchronous), and the full SETTLE sequence repeats on release.

Test Plan:
- Reset, then hold a_in=1, b_in=1 through SETTLE -> ab_filt=2'b11 after SETTLE, step=0 and err=0 throughout, FSM in RUN at cycle SETTLE_LEN.
- From 00, drive one full up cycle 10,11,01,00, each held 10 cycles, FILT_LEN=4 -> exactly 4 step pulses, each 1 cycle wide, direc=1; first pulse 6 edges after the first pin change is captured.
- From 00, drive the down cycle 01,11,10,00 -> 4 step pulses with direc=0. Chained into the counter from 0, the count reads 12.
- Glitch a_in high for 3 cycles (FILT_LEN=4) -> ab_filt unchanged, no step, no err. A 4-cycle pulse -> ab_filt updates, step fires.
- Change 00->11 on the same clk edge, held -> one err pulse, err_flag=1, no step. Assert err_clr for 1 cycle -> err_flag=0. err_clr concurrent with a new err -> err_flag stays 1.
- en=0 during 2 up transitions, then en=1 with no further pin activity -> zero step pulses. Assert rst mid-sequence -> outputs 0 asynchronously, and SETTLE repeats.
